// File: rtl/turn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : turn_scheduler
//  Purpose  : Player turn sequencing: active/next player, step countdown,
//             round counting and game-over detection. The per-step countdown
//             and timeout are built only when STEP_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module turn_scheduler #(
  parameter int MAX_PLAYER_CNT      = 7,
  parameter int LOG2_MAX_PLAYER_CNT = 3,
  parameter int MAX_STEP_TIME       = 15,
  parameter int LOG2_MAX_STEP_TIME  = 4,
  parameter int LOG2_MAX_ROUND      = 12,
  parameter int TICKS_PER_SEC       = 50_000_000
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [MAX_PLAYER_CNT-1:0]      alive_mask,
  input  logic                           move_done,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] next_player,
  output logic [LOG2_MAX_STEP_TIME-1:0]  step_timer,
  output logic [LOG2_MAX_ROUND-1:0]      round,
  output logic                           turn_start,
  output logic                           game_over,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] winner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TURN    = 2'd1,
    S_ADVANCE = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  localparam logic [LOG2_MAX_STEP_TIME-1:0] c_step_reload = LOG2_MAX_STEP_TIME'(MAX_STEP_TIME);
  localparam logic [MAX_PLAYER_CNT-1:0]     c_one_hot0    = MAX_PLAYER_CNT'(1);

`ifdef STEP_TIMEOUT_EN
  localparam int c_presc_w = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICKS_PER_SEC - 1);
  logic [c_presc_w-1:0] r_presc;
  logic                 w_tick;
`endif

  state_t                           r_state;
  state_t                           w_state_next;
  logic [LOG2_MAX_PLAYER_CNT-1:0]   r_current;
  logic [LOG2_MAX_PLAYER_CNT-1:0]   r_next;
  logic [LOG2_MAX_PLAYER_CNT-1:0]   r_winner;
  logic [LOG2_MAX_STEP_TIME-1:0]    r_timer;
  logic [LOG2_MAX_ROUND-1:0]        r_round;
  logic                             r_turn_start;
  logic                             r_game_over;
  logic [LOG2_MAX_PLAYER_CNT-1:0]   w_adv_target;
  logic [LOG2_MAX_PLAYER_CNT-1:0]   w_lowest;
  logic                             w_cur_alive;
  logic                             w_timeout;
  int                               w_alive_cnt;

  // First alive id strictly after cur, wrapping MAX_PLAYER_CNT -> 1; cur itself
  // is never returned. With cur = 0 this yields the lowest alive id.
  function automatic logic [LOG2_MAX_PLAYER_CNT-1:0] f_next_alive(
    input logic [LOG2_MAX_PLAYER_CNT-1:0] cur,
    input logic [MAX_PLAYER_CNT-1:0]      mask
  );
    logic [LOG2_MAX_PLAYER_CNT-1:0] result;
    logic                           found;
    int                             cand;
    result = '0;
    found  = 1'b0;
    for (int i = 1; i <= MAX_PLAYER_CNT; i++) begin
      cand = ((int'(cur) + i - 1) % MAX_PLAYER_CNT) + 1;
      if (!found && (cand != int'(cur)) && |(mask & (c_one_hot0 << (cand - 1)))) begin
        result = LOG2_MAX_PLAYER_CNT'(cand);
        found  = 1'b1;
      end
    end
    return result;
  endfunction

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    w_alive_cnt  = $countones(alive_mask);
    w_adv_target = f_next_alive(r_current, alive_mask);
    w_lowest     = f_next_alive('0, alive_mask);
    w_cur_alive  = |(alive_mask & (c_one_hot0 << (r_current - LOG2_MAX_PLAYER_CNT'(1))));
`ifdef STEP_TIMEOUT_EN
    w_tick       = (r_presc == c_presc_last);
    w_timeout    = (r_state == S_TURN) && w_tick && (r_timer == LOG2_MAX_STEP_TIME'(1));
`endif
    case (r_state)
      S_IDLE:    if (start) w_state_next = (w_alive_cnt >= 2) ? S_TURN : S_OVER;
      S_TURN:    if (move_done || w_timeout || !w_cur_alive) w_state_next = S_ADVANCE;
      S_ADVANCE: w_state_next = (w_alive_cnt >= 2) ? S_TURN : S_OVER;
      S_OVER:    w_state_next = S_OVER;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_current    <= '0;
      r_next       <= '0;
      r_winner     <= '0;
      r_timer      <= c_step_reload;
      r_round      <= '0;
      r_turn_start <= 1'b0;
      r_game_over  <= 1'b0;
`ifdef STEP_TIMEOUT_EN
      r_presc      <= '0;
`endif
    end else begin
      r_turn_start <= 1'b0;
      // Follows the registered current player, hence one cycle behind it.
      r_next       <= (r_current == '0) ? '0 : f_next_alive(r_current, alive_mask);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_alive_cnt >= 2) begin
              r_current    <= w_lowest;
              r_round      <= LOG2_MAX_ROUND'(1);
              r_timer      <= c_step_reload;
              r_turn_start <= 1'b1;
`ifdef STEP_TIMEOUT_EN
              r_presc      <= '0;
`endif
            end else begin
              r_winner    <= w_lowest;
              r_game_over <= 1'b1;
            end
          end
        end
        S_TURN: begin
`ifdef STEP_TIMEOUT_EN
          if (w_tick) begin
            r_presc <= '0;
            if (r_timer != '0) r_timer <= r_timer - 1'b1;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
`endif
        end
        S_ADVANCE: begin
          if (w_alive_cnt >= 2) begin
            r_current    <= w_adv_target;
            // A wrap back to a lower-or-equal id closes the round.
            if ((w_adv_target <= r_current) && (r_round != '1))
              r_round <= r_round + 1'b1;
            r_timer      <= c_step_reload;
            r_turn_start <= 1'b1;
`ifdef STEP_TIMEOUT_EN
            r_presc      <= '0;
`endif
          end else begin
            r_current   <= '0;
            r_winner    <= w_lowest;
            r_game_over <= 1'b1;
          end
        end
        S_OVER: begin
          r_current <= '0;
        end
        default: begin
          r_current <= '0;
        end
      endcase
    end
  end

  assign current_player = r_current;
  assign next_player    = r_next;
  assign step_timer     = r_timer;
  assign round          = r_round;
  assign turn_start     = r_turn_start;
  assign game_over      = r_game_over;
  assign winner         = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_turn_scheduler.sv
`default_nettype none
// Testbench for turn_scheduler: directed scenarios plus randomized games
// checked against a queue-based model of the turn order rules.
module tb_turn_scheduler;
  localparam int NP  = 7;
  localparam int PW  = 3;
  localparam int ST  = 3;
  localparam int SW  = 2;
  localparam int RW  = 3;
  localparam int TPS = 4;
  localparam int RMAX = (1 << RW) - 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [NP-1:0] alive_mask;
  logic          move_done;
  logic [PW-1:0] current_player;
  logic [PW-1:0] next_player;
  logic [SW-1:0] step_timer;
  logic [RW-1:0] round;
  logic          turn_start;
  logic          game_over;
  logic [PW-1:0] winner;

  int passed = 0;
  int total  = 0;
  int m_cur;
  int m_round;

  always #5 clock = ~clock;

  turn_scheduler #(
    .MAX_PLAYER_CNT(NP), .LOG2_MAX_PLAYER_CNT(PW), .MAX_STEP_TIME(ST),
    .LOG2_MAX_STEP_TIME(SW), .LOG2_MAX_ROUND(RW), .TICKS_PER_SEC(TPS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .alive_mask(alive_mask),
    .move_done(move_done), .current_player(current_player), .next_player(next_player),
    .step_timer(step_timer), .round(round), .turn_start(turn_start),
    .game_over(game_over), .winner(winner)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic bit is_alive(logic [NP-1:0] m, int id);
    logic [NP-1:0] t;
    t = m >> (id - 1);
    return t[0];
  endfunction

  function automatic int alive_count(logic [NP-1:0] m);
    int n = 0;
    for (int i = 1; i <= NP; i++) if (is_alive(m, i)) n++;
    return n;
  endfunction

  function automatic int lowest_alive(logic [NP-1:0] m);
    for (int i = 1; i <= NP; i++) if (is_alive(m, i)) return i;
    return 0;
  endfunction

  // Turn order: sorted list of other alive ids; take the first one above cur, else wrap.
  function automatic int model_next(int cur, logic [NP-1:0] m);
    int q[$];
    for (int i = 1; i <= NP; i++) if (is_alive(m, i) && i != cur) q.push_back(i);
    if (q.size() == 0) return 0;
    foreach (q[j]) if (q[j] > cur) return q[j];
    return q[0];
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; move_done = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic do_start(logic [NP-1:0] m);
    alive_mask = m;
    start = 1'b1;
    step();
    start = 1'b0;
    m_cur = lowest_alive(m);
    m_round = 1;
  endtask

  // Model update for one advance; returns 1 when the game should end.
  function automatic bit model_advance(logic [NP-1:0] m);
    int nxt;
    if (alive_count(m) <= 1) return 1'b1;
    nxt = model_next(m_cur, m);
    if (nxt <= m_cur && m_round < RMAX) m_round++;
    m_cur = nxt;
    return 1'b0;
  endfunction

  task automatic test_reset();
    alive_mask = '0;
    reset_n = 1'b0; start = 1'b0; move_done = 1'b0;
    step(); step();
    total++;
    if ({current_player, next_player, round, winner} !== '0) $display("FAIL reset_ids: got cur=%0d next=%0d round=%0d win=%0d, expected all 0", current_player, next_player, round, winner);
    else passed++;
    total++;
    if (step_timer !== SW'(ST)) $display("FAIL reset_timer: got %0d expected %0d", step_timer, ST);
    else passed++;
    total++;
    if ({turn_start, game_over} !== 2'b00) $display("FAIL reset_flags: got ts=%b go=%b expected 0 0", turn_start, game_over);
    else passed++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_start();
    do_start(7'b0010110);
    total++;
    if (current_player !== PW'(2) || round !== RW'(1) || turn_start !== 1'b1 || step_timer !== SW'(ST))
      $display("FAIL start: got cur=%0d round=%0d ts=%b timer=%0d expected 2 1 1 %0d", current_player, round, turn_start, step_timer, ST);
    else passed++;
    step();
    total++;
    if (next_player !== PW'(3) || turn_start !== 1'b0) $display("FAIL start_next: got next=%0d ts=%b expected 3 0", next_player, turn_start);
    else passed++;
  endtask

  task automatic test_moves();
    for (int k = 0; k < 3; k++) begin
      int old_cur = m_cur;
      move_done = 1'b1;
      step();
      move_done = 1'b0;
      total++;
      if (current_player !== PW'(old_cur) || turn_start !== 1'b0) $display("FAIL move_lat: got cur=%0d ts=%b expected %0d 0", current_player, turn_start, old_cur);
      else passed++;
      step();
      void'(model_advance(alive_mask));
      total++;
      if (current_player !== PW'(m_cur) || round !== RW'(m_round) || turn_start !== 1'b1)
        $display("FAIL move: got cur=%0d round=%0d ts=%b expected %0d %0d 1", current_player, round, turn_start, m_cur, m_round);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int exp_cur;
    exp_cur = model_next(m_cur, alive_mask);
    move_done = 1'b1;
    step(); step();
    move_done = 1'b0;
    void'(model_advance(alive_mask));
    total++;
    if (current_player !== PW'(exp_cur)) $display("FAIL b2b_adv: got %0d expected %0d", current_player, exp_cur);
    else passed++;
    step(); step();
    total++;
    if (current_player !== PW'(m_cur) || round !== RW'(m_round)) $display("FAIL b2b_once: got cur=%0d round=%0d expected %0d %0d", current_player, round, m_cur, m_round);
    else passed++;
  endtask

  task automatic test_over();
    while (m_cur != 5) begin
      move_done = 1'b1; step(); move_done = 1'b0; step();
      void'(model_advance(alive_mask));
    end
    alive_mask = 7'b0000010;
    step();
    total++;
    if (game_over !== 1'b0) $display("FAIL over_adv: got game_over=%b expected 0", game_over);
    else passed++;
    step();
    total++;
    if (game_over !== 1'b1 || winner !== PW'(2) || current_player !== '0)
      $display("FAIL over: got go=%b win=%0d cur=%0d expected 1 2 0", game_over, winner, current_player);
    else passed++;
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    step();
    total++;
    if (game_over !== 1'b1 || current_player !== '0 || next_player !== '0 || turn_start !== 1'b0)
      $display("FAIL over_hold: got go=%b cur=%0d next=%0d ts=%b expected 1 0 0 0", game_over, current_player, next_player, turn_start);
    else passed++;
  endtask

  task automatic test_start_few();
    logic [NP-1:0] masks [2];
    masks[0] = 7'b0100000;
    masks[1] = 7'b0000000;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      do_start(masks[k]);
      total++;
      if (game_over !== 1'b1 || winner !== PW'(lowest_alive(masks[k])) || current_player !== '0)
        $display("FAIL start_few: got go=%b win=%0d cur=%0d expected 1 %0d 0", game_over, winner, current_player, lowest_alive(masks[k]));
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int g = 0; g < 6; g++) begin
      logic [NP-1:0] m;
      int tc;
      bit over;
      do_reset();
      do m = NP'($urandom); while (alive_count(m) < 2);
      do_start(m);
      total++;
      if (current_player !== PW'(m_cur)) $display("FAIL rnd_start: got %0d expected %0d", current_player, m_cur);
      else passed++;
      tc = 0;
      over = 1'b0;
      for (int op_i = 0; op_i < 25 && !over; op_i++) begin
        int op = $urandom_range(0, 9);
        int w = $urandom_range(0, 3);
        if (tc + w + 2 > 10) w = 0;
        repeat (w) step();
        tc += w;
        if (op >= 8 && alive_count(alive_mask) >= 3 && tc + 3 <= 10) begin
          int victim;
          do victim = $urandom_range(1, NP); while (!is_alive(alive_mask, victim) || victim == m_cur);
          alive_mask = alive_mask & ~(NP'(1) << (victim - 1));
          step();
          tc++;
          total++;
          if (next_player !== PW'(model_next(m_cur, alive_mask))) $display("FAIL rnd_next: got %0d expected %0d", next_player, model_next(m_cur, alive_mask));
          else passed++;
        end else begin
          if (op >= 6) begin
            alive_mask = alive_mask & ~(NP'(1) << (m_cur - 1));
            if ($urandom_range(0, 1) == 1) alive_mask = alive_mask & NP'($urandom);
          end else begin
            move_done = 1'b1;
          end
          step();
          move_done = 1'b0;
          step();
          over = model_advance(alive_mask);
          if (over) begin
            total++;
            if (game_over !== 1'b1 || winner !== PW'(lowest_alive(alive_mask)) || current_player !== '0)
              $display("FAIL rnd_over: got go=%b win=%0d cur=%0d expected 1 %0d 0", game_over, winner, current_player, lowest_alive(alive_mask));
            else passed++;
          end else begin
            total++;
            if (current_player !== PW'(m_cur) || round !== RW'(m_round) || turn_start !== 1'b1)
              $display("FAIL rnd_adv: got cur=%0d round=%0d ts=%b expected %0d %0d 1", current_player, round, turn_start, m_cur, m_round);
            else passed++;
            step();
            tc = 1;
            total++;
            if (next_player !== PW'(model_next(m_cur, alive_mask))) $display("FAIL rnd_lag: got %0d expected %0d", next_player, model_next(m_cur, alive_mask));
            else passed++;
          end
        end
      end
    end
  endtask

  task automatic test_round_saturation();
    do_reset();
    do_start(7'b0000011);
    for (int k = 0; k < 20; k++) begin
      move_done = 1'b1; step(); move_done = 1'b0; step();
      void'(model_advance(alive_mask));
    end
    total++;
    if (round !== RW'(m_round) || current_player !== PW'(m_cur))
      $display("FAIL round_sat: got round=%0d cur=%0d expected %0d %0d", round, current_player, m_round, m_cur);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_start(7'b0010110);
    repeat (TPS) step();
`ifdef STEP_TIMEOUT_EN
    total++;
    if (step_timer !== SW'(ST - 1)) $display("FAIL mid_timer: got %0d expected %0d", step_timer, ST - 1);
    else passed++;
`endif
    reset_n = 1'b0;
    move_done = 1'b1;
    step();
    reset_n = 1'b1;
    move_done = 1'b0;
    total++;
    if ({current_player, next_player, round, winner, turn_start, game_over} !== '0 || step_timer !== SW'(ST))
      $display("FAIL mid_reset: got cur=%0d next=%0d round=%0d win=%0d ts=%b go=%b timer=%0d expected zeros timer=%0d",
               current_player, next_player, round, winner, turn_start, game_over, step_timer, ST);
    else passed++;
    step(); step();
    total++;
    if (current_player !== '0 || game_over !== 1'b0) $display("FAIL mid_idle: got cur=%0d go=%b expected 0 0", current_player, game_over);
    else passed++;
  endtask

`ifdef STEP_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    do_start(7'b0010110);
    for (int j = 0; j <= ST * TPS; j++) begin
      if (j > 0) step();
      total++;
      if (step_timer !== SW'(ST - j / TPS) || current_player !== PW'(m_cur))
        $display("FAIL timeout_cnt: j=%0d got timer=%0d cur=%0d expected %0d %0d", j, step_timer, current_player, ST - j / TPS, m_cur);
      else passed++;
    end
    step();
    void'(model_advance(alive_mask));
    total++;
    if (current_player !== PW'(m_cur) || step_timer !== SW'(ST) || turn_start !== 1'b1)
      $display("FAIL timeout_adv: got cur=%0d timer=%0d ts=%b expected %0d %0d 1", current_player, step_timer, turn_start, m_cur, ST);
    else passed++;
  endtask

  task automatic test_simultaneous();
    for (int t = 0; t < 2; t++) begin
      repeat (ST * TPS - 1) step();
      move_done = 1'b1;
      step();
      move_done = 1'b0;
      total++;
      if (step_timer !== '0) $display("FAIL simul_zero: got %0d expected 0", step_timer);
      else passed++;
      step();
      void'(model_advance(alive_mask));
      step();
      total++;
      if (current_player !== PW'(m_cur) || round !== RW'(m_round) || step_timer !== SW'(ST))
        $display("FAIL simul: got cur=%0d round=%0d timer=%0d expected %0d %0d %0d", current_player, round, step_timer, m_cur, m_round, ST);
      else passed++;
      repeat (ST * TPS - 1) step();
      step();
      move_done = 1'b0;
      step();
      void'(model_advance(alive_mask));
      step();
      repeat (ST * TPS - 2) step();
    end
  endtask
`else
  task automatic test_no_timeout();
    int bad = 0;
    do_reset();
    do_start(7'b0010110);
    for (int j = 0; j < 100; j++) begin
      step();
      if (step_timer !== SW'(ST) || current_player !== PW'(2)) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL no_timeout: got %0d bad cycles expected 0", bad);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_moves();
    test_back_to_back();
    test_over();
    test_start_few();
    test_random();
    test_round_saturation();
    test_reset_mid();
`ifdef STEP_TIMEOUT_EN
    test_timeout();
    do_reset();
    do_start(7'b0010110);
    move_done = 1'b1; step(); move_done = 1'b0; step();
    void'(model_advance(alive_mask));
    test_simultaneous();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
